// File: rtl/fifo_pkg.sv
// Shared FIFO sizing constants and pointer/count types for the dual-port-RAM FIFO controller.
package fifo_pkg;

    localparam int unsigned FIFO_DW    = 8;
    localparam int unsigned FIFO_AW    = 4;
    localparam int unsigned FIFO_DEPTH = 16;

    typedef logic [FIFO_AW-1:0] fifo_ptr_t;
    typedef logic [FIFO_AW:0]   fifo_count_t;

endpackage

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller driving an external dual-port synchronous RAM (port A write, port B read).
// Define FIFO_ERR_FLAGS_EN to build the sticky ovf/udf error registers; otherwise they tie to 0.
module dpram_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned DW    = FIFO_DW,
    parameter int unsigned AW    = FIFO_AW,
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    output logic          full,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          ram_we_a,
    output logic [AW-1:0] ram_addr_a,
    output logic [DW-1:0] ram_din_a,
    output logic          ram_we_b,
    output logic [AW-1:0] ram_addr_b,
    input  logic [DW-1:0] ram_dout_b,
    output logic          ovf,
    output logic          udf
);

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count_nxt;
    logic          wr_acc;
    logic          rd_acc;

    // Acceptance and next occupancy, all from pre-edge state.
    always_comb begin
        wr_acc    = wr_en & ~full;
        rd_acc    = rd_en & ~empty;
        count_nxt = count;
        if (wr_acc && !rd_acc) begin
            count_nxt = count + (AW+1)'(1);
        end else if (rd_acc && !wr_acc) begin
            count_nxt = count - (AW+1)'(1);
        end
    end

    assign ram_we_a   = wr_acc;
    assign ram_addr_a = wptr;
    assign ram_din_a  = wr_data;
    assign ram_we_b   = 1'b0;
    assign ram_addr_b = rptr;
    // RAM output is already registered, so the data passes straight through.
    assign rd_data    = ram_dout_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            rd_valid <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + AW'(1);
            end
            if (rd_acc) begin
                rptr <= rptr + AW'(1);
            end
            count    <= count_nxt;
            full     <= (count_nxt == (AW+1)'(DEPTH));
            empty    <= (count_nxt == '0);
            rd_valid <= rd_acc;
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic ovf_q;
    logic udf_q;

    // Sticky until reset: rejected write sets ovf, rejected read sets udf.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q | (wr_en & full);
            udf_q <= udf_q | (rd_en & empty);
        end
    end

    assign ovf = ovf_q;
    assign udf = udf_q;
`else
    assign ovf = 1'b0;
    assign udf = 1'b0;
`endif

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Self-checking bench for dpram_fifo_ctrl with a behavioural 16x8 dual-port synchronous RAM.
module tb_dpram_fifo_ctrl;
    import fifo_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        full;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        empty;
    logic [4:0]  count;
    logic        ram_we_a;
    logic [3:0]  ram_addr_a;
    logic [7:0]  ram_din_a;
    logic        ram_we_b;
    logic [3:0]  ram_addr_b;
    logic [7:0]  ram_dout_b;
    logic        ovf;
    logic        udf;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  model_q[$];
    logic [7:0]  exp_q[$];
    fifo_ptr_t   m_wptr;
    fifo_ptr_t   m_rptr;
    logic        m_ovf;
    logic        m_udf;

    always #5 clk = ~clk;

    dpram_fifo_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .empty      (empty),
        .count      (count),
        .ram_we_a   (ram_we_a),
        .ram_addr_a (ram_addr_a),
        .ram_din_a  (ram_din_a),
        .ram_we_b   (ram_we_b),
        .ram_addr_b (ram_addr_b),
        .ram_dout_b (ram_dout_b),
        .ovf        (ovf),
        .udf        (udf)
    );

    // External dual-port RAM: synchronous write on A, registered read on B.
    logic [7:0] mem [16];
    always_ff @(posedge clk) begin
        if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
        ram_dout_b <= mem[ram_addr_b];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag);
        fifo_count_t n;
        n = fifo_count_t'(model_q.size());
        check({tag, ":count"}, 32'(count), 32'(n));
        check({tag, ":full"},  32'(full),  32'(n == 5'd16));
        check({tag, ":empty"}, 32'(empty), 32'(n == 5'd0));
        check({tag, ":ovf"},   32'(ovf),   32'(m_ovf));
        check({tag, ":udf"},   32'(udf),   32'(m_udf));
    endtask

    // One clock of stimulus: drive at negedge, check RAM drive, then check results after the edge.
    task automatic step(input logic w, input logic [7:0] wd, input logic r);
        logic wacc;
        logic racc;
        @(negedge clk);
        wr_en   = w;
        wr_data = wd;
        rd_en   = r;
        #1;
        wacc = w && (model_q.size() < 16);
        racc = r && (model_q.size() > 0);
        check("ram_we_a", 32'(ram_we_a), 32'(wacc));
        check("ram_we_b", 32'(ram_we_b), 32'(1'b0));
        check("ram_addr_b", 32'(ram_addr_b), 32'(m_rptr));
        if (wacc) begin
            check("ram_addr_a", 32'(ram_addr_a), 32'(m_wptr));
            check("ram_din_a", 32'(ram_din_a), 32'(wd));
        end
        @(posedge clk);
        #1;
        if (racc) begin
            exp_q.push_back(model_q.pop_front());
            m_rptr = m_rptr + 4'd1;
        end
        if (wacc) begin
            model_q.push_back(wd);
            m_wptr = m_wptr + 4'd1;
        end
`ifdef FIFO_ERR_FLAGS_EN
        if (w && !wacc) m_ovf = 1'b1;
        if (r && !racc) m_udf = 1'b1;
`endif
        check("rd_valid", 32'(rd_valid), 32'(racc));
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("rd_unexpected", 32'(rd_data), 32'hFFFF_FFFF);
            end else begin
                check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
            end
        end
        check_status("step");
    endtask

    task automatic model_reset();
        model_q.delete();
        exp_q.delete();
        m_wptr = '0;
        m_rptr = '0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        rd_en   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset:rd_valid", 32'(rd_valid), 32'd0);
        check_status("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset stays empty.
        step(1'b0, 8'h00, 1'b0);

        // Fill with 0x01..0x10, then drain in order.
        for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);

        // Overflow at full; 0xAA must never come back.
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
        step(1'b1, 8'hAA, 1'b0);

        // Simultaneous write+read at full: read wins, count drops to 15.
        step(1'b1, 8'hBB, 1'b1);
        for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1);

        // Simultaneous write+read at empty: write wins, count becomes 1.
        step(1'b1, 8'h30, 1'b1);
        step(1'b1, 8'h31, 1'b1);
        step(1'b0, 8'h00, 1'b1);

        // Fill 10 / read 10, then 0x5A..0x63 straddling the 15 -> 0 wrap.
        for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h5A + i), 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1);

        // Underflow at empty.
        step(1'b0, 8'h00, 1'b1);

        // Reset mid-burst with a read in flight.
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h70 + i), 1'b0);
        step(1'b1, 8'h74, 1'b1);
        #2;
        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        #1;
        model_reset();
        check("midrst:rd_valid", 32'(rd_valid), 32'd0);
        check_status("midrst");
        @(negedge clk);
        rst_n = 1'b1;

        // First access after reset uses address 0.
        step(1'b1, 8'h77, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dpram_fifo_ctrl.md
DPRAM_FIFO_CTRL -- requirements
Module: dpram_fifo_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset:
- clk  in  1  rising-edge clock for all state.
- rst_n  in  1  asynchronous active-low reset.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- DW, 8, data width.
- AW, 4, RAM address width.
- DEPTH, 16, entries (2**AW).
REQ-003 The block SHALL have these write-side ports:
- wr_en  in  1  write request.
- wr_data  in  DW  write data.
- full  out  1  no free entry.
REQ-004 The block SHALL have these read-side ports:
- rd_en  in  1  read request.
- rd_data  out  DW  read data.
- rd_valid  out  1  rd_data valid this cycle.
- empty  out  1  no stored entry.
- count  out  AW+1  stored entries, 0..DEPTH.
REQ-005 The block SHALL have these RAM-side ports, connected to an external 16x8 dual-port synchronous RAM (port A write, port B read):
- ram_we_a  out  1
- ram_addr_a  out  AW
- ram_din_a  out  DW
- ram_we_b  out  1  constant 0.
- ram_addr_b  out  AW
- ram_dout_b  in  DW  RAM registered read data.
REQ-006 The block SHALL have these error ports:
- ovf  out  1  sticky overflow.
- udf  out  1  sticky underflow.

Function
REQ-007 Write acceptance SHALL be wr_acc = wr_en & !full, evaluated on pre-edge state.
REQ-008 Read acceptance SHALL be rd_acc = rd_en & !empty, evaluated on pre-edge state.
REQ-009 Write drive SHALL be combinational: ram_we_a = wr_acc, ram_addr_a = wptr, ram_din_a = wr_data.
REQ-010 On wr_acc, wptr SHALL increment modulo DEPTH (15 -> 0).
REQ-011 ram_addr_b SHALL be driven combinationally with rptr.
REQ-012 On rd_acc, rptr SHALL increment modulo DEPTH.
REQ-013 Read latency SHALL be one cycle: after an edge with rd_acc, rd_valid SHALL be 1 for exactly one cycle, with rd_data = ram_dout_b passed through combinationally; otherwise rd_valid SHALL be 0.
REQ-014 count SHALL update as follows: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
REQ-015 Flags SHALL be registered, derived from next count: full = (count == DEPTH), empty = (count == 0).
REQ-016 On simultaneous wr_en and rd_en while full, the read SHALL be accepted, the write rejected, and count SHALL become DEPTH-1.
REQ-017 On simultaneous wr_en and rd_en while empty, the write SHALL be accepted, the read rejected, and count SHALL become 1.
REQ-018 An entry written at edge N SHALL be readable no earlier than edge N+1, so no same-address read/write collision occurs.
REQ-019 A rejected write SHALL set ovf; a rejected read SHALL set udf. Both SHALL hold until reset.

Reset
REQ-020 On rst_n low, asynchronously, the block SHALL force: wptr = 0, rptr = 0, count = 0, empty = 1, full = 0, rd_valid = 0, ovf = 0, udf = 0.
REQ-021 Reset asserted mid-operation SHALL discard all entries. An in-flight rd_valid SHALL be dropped, and RAM contents SHALL be ignored.
REQ-022 Reset deassertion SHALL be taken synchronously by the surrounding design; the first accepted access SHALL be at the first edge after deassertion.

Configuration
REQ-023 Macro FIFO_ERR_FLAGS_EN defined: ovf and udf SHALL behave per REQ-019.
REQ-024 Macro FIFO_ERR_FLAGS_EN undefined: ovf and udf SHALL be constant 0, no error registers SHALL be built, and ports SHALL be unchanged.

Structure
REQ-025 A shared package fifo_pkg SHALL hold:
- FIFO_DW = 8, FIFO_AW = 4, FIFO_DEPTH = 16.
- A typedef for the AW-bit pointer.
- A typedef for the AW+1-bit count.
REQ-026 The block SHALL be a single module with no sub-modules. The RAM SHALL be instantiated by the parent, not inside this block.

Verification
REQ-027 The bench SHALL instantiate dpram_fifo_ctrl with the dual-port RAM and cover these scenarios:
- Reset, then idle -> empty = 1, full = 0, count = 0, rd_valid = 0.
- Write 0x01..0x10 (16 words), then 16 reads -> full = 1 after the 16th write; rd_data = 0x01..0x10 in order, each one cycle after rd_en; empty = 1 at end.
- At full, wr_en = 1 with wr_data 0xAA -> write rejected, count = 16, ovf = 1; later reads never return 0xAA.
- At full, wr_en = rd_en = 1 -> count = 15, full = 0; oldest word read.
- Fill 10, read 10, write 0x5A..0x63 (10 words) -> pointers wrap 15 -> 0; reads return 0x5A..0x63.
- At empty, rd_en = 1 -> rd_valid = 0, udf = 1. Assert rst_n low mid-burst -> all outputs return to reset values immediately.
